// File: rtl/audio_dac_serializer.sv
// ============================================================================
//  Module   : audio_dac_serializer
//  Purpose  : Paces voice sample requests, buffers stereo frames in a FIFO and
//             serializes them to the codec DAC (left-justified, 16-bit stereo).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_dac_serializer #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   sample_l,
    input  logic [15:0]                   sample_r,
    output logic                          audio_out_allowed,
    output logic                          dac_bclk,
    output logic                          dac_lrck,
    output logic                          dac_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    underrun_count
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_DW = $clog2(CLK_DIV);
    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(CLK_DIV - 1);
    localparam logic [c_LW-1:0] c_FULL     = c_LW'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        PEND_IDLE = 1'b0,
        PEND_WAIT = 1'b1
    } pend_state_t;

    pend_state_t     r_state;
    logic            r_aoa;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;
    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [c_DW-1:0] r_div;
    logic            r_bclk;
    logic [4:0]      r_slot;
    logic            r_lrck;
    logic [31:0]     r_shift;
    logic [7:0]      r_underrun;

    logic            w_req_ok;
    logic            w_fall;
    logic            w_frame_start;
    logic            w_push;
    logic            w_pop;
    logic [4:0]      w_slot_next;

    assign w_req_ok      = (r_state == PEND_IDLE) && (r_level < c_FULL);
    assign w_fall        = (r_div == c_DIV_LAST) && r_bclk;
    assign w_frame_start = w_fall && (r_slot == 5'd31);
    assign w_push        = (r_state == PEND_WAIT);
    // Emptiness is judged on the pre-write level so a same-cycle write waits a frame.
    assign w_pop         = w_frame_start && (r_level != '0);
    assign w_slot_next   = r_slot + 5'd1;

    // Request / capture handshake: pulse, then capture on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PEND_IDLE;
            r_aoa   <= 1'b0;
        end else begin
            case (r_state)
                PEND_IDLE: begin
                    if (w_req_ok) begin
                        r_state <= PEND_WAIT;
                        r_aoa   <= 1'b1;
                    end else begin
                        r_aoa   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= PEND_IDLE;
                    r_aoa   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {sample_l, sample_r};
        end
    end

    // Free-running bit clock and slot sequencer; data/LRCK move on BCLK falling edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div      <= '0;
            r_bclk     <= 1'b0;
            r_slot     <= 5'd31;
            r_lrck     <= 1'b0;
            r_shift    <= '0;
            r_underrun <= '0;
        end else begin
            if (r_div == c_DIV_LAST) begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_div  <= r_div + 1'b1;
            end

            if (w_fall) begin
                r_slot <= w_slot_next;
                r_lrck <= w_slot_next[4];
                if (w_frame_start) begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                    end else begin
                        r_shift <= '0;
                        if (r_underrun != 8'hFF) begin
                            r_underrun <= r_underrun + 8'd1;
                        end
                    end
                end else begin
                    r_shift <= {r_shift[30:0], 1'b0};
                end
            end
        end
    end

    assign audio_out_allowed = r_aoa;
    assign dac_bclk          = r_bclk;
    assign dac_lrck          = r_lrck;
    assign dac_data          = r_shift[31];
    assign fifo_level        = r_level;
    assign underrun_count    = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_audio_dac_serializer.sv
// ============================================================================
//  Module   : tb_audio_dac_serializer
//  Purpose  : Self-checking bench for audio_dac_serializer (model + vectors).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_audio_dac_serializer;

    localparam int C  = 4;
    localparam int D  = 4;
    localparam int FR = 64 * C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sample_l = '0;
    logic [15:0] sample_r = '0;
    logic        audio_out_allowed, dac_bclk, dac_lrck, dac_data;
    logic [2:0]  fifo_level;
    logic [7:0]  underrun_count;

    logic        rst2 = 1'b1;
    logic        aoa2, bclk2, lrck2, data2;
    logic [1:0]  level2;
    logic [7:0]  under2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    audio_dac_serializer #(.CLK_DIV(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .sample_l(sample_l), .sample_r(sample_r),
        .audio_out_allowed(audio_out_allowed), .dac_bclk(dac_bclk),
        .dac_lrck(dac_lrck), .dac_data(dac_data),
        .fifo_level(fifo_level), .underrun_count(underrun_count)
    );

    audio_dac_serializer #(.CLK_DIV(2), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst2), .sample_l(16'hFFFF), .sample_r(16'hFFFF),
        .audio_out_allowed(aoa2), .dac_bclk(bclk2),
        .dac_lrck(lrck2), .dac_data(data2),
        .fifo_level(level2), .underrun_count(under2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: a queue of frames plus the frame/bit timing arithmetic.
    int          mt = 0;
    bit          m_pend = 0;
    bit [31:0]   mq[$];
    bit [31:0]   m_frame = 0;
    int          m_under = 0;
    bit          mask = 0;
    bit          chk_en = 0;

    always @(posedge clk) begin
        if (rst) begin
            mt = 0; m_pend = 0; mq.delete(); m_frame = 0; m_under = 0;
        end else begin
            int  size_b;
            bit  pend_b;
            size_b = mq.size();
            pend_b = m_pend;
            mt++;
            if (mt >= 2*C && (mt - 2*C) % FR == 0) begin
                if (mq.size() == 0) begin
                    m_frame = 0;
                    if (m_under < 255) m_under++;
                end else begin
                    m_frame = mq.pop_front();
                end
            end
            if (pend_b) mq.push_back({sample_l, sample_r});
            m_pend = !pend_b && (size_b < D) && !mask;
        end
    end

    function automatic logic exp_lrck(int t);
        if (t < 2*C) return 1'b0;
        return (((t - 2*C) / (2*C)) % 32) >= 16;
    endfunction

    function automatic logic exp_data(int t);
        int k;
        if (t < 2*C) return 1'b0;
        k = ((t - 2*C) / (2*C)) % 32;
        return m_frame[31-k];
    endfunction

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("model aoa",   32'(audio_out_allowed), 32'(m_pend));
            check("model level", 32'(fifo_level),        32'(mq.size()));
            check("model under", 32'(underrun_count),    32'(m_under));
            check("model bclk",  32'(dac_bclk),          32'((mt / C) % 2));
            check("model lrck",  32'(dac_lrck),          32'(exp_lrck(mt)));
            check("model data",  32'(dac_data),          32'(exp_data(mt)));
        end
    end

    task set_mask(input bit m);
        mask = m;
        if (m) force dut.w_req_ok = 1'b0;
        else   release dut.w_req_ok;
    endtask

    bit rand_voice = 0;
    bit rand_mask  = 0;

    always @(negedge clk) begin
        if (rand_voice && audio_out_allowed) begin
            sample_l = 16'($urandom);
            sample_r = 16'($urandom);
        end
        if (rand_mask) begin
            if (!mask && $urandom_range(0, 63) == 0)        set_mask(1'b1);
            else if (mask && $urandom_range(0, 599) == 0)   set_mask(1'b0);
        end
    end

    task automatic wait_until(input int n);
        int g;
        g = 0;
        while (mt < n) begin
            @(negedge clk);
            g++;
            if (g > 200000) begin
                n_fail++;
                $display("FAIL wait_until: timed out at cycle %0d waiting for %0d", mt, n);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic collect(input int fs, output logic [31:0] w, output logic [31:0] lr);
        w  = '0;
        lr = '0;
        for (int k = 0; k < 32; k++) begin
            wait_until(fs + 2*C*k + C);
            w  = {w[30:0], dac_data};
            lr = {lr[30:0], dac_lrck};
        end
    endtask

    function automatic int next_frame(input int x);
        return 2*C + FR * ((x - 2*C + FR - 1) / FR);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " aoa"},   32'(audio_out_allowed), 32'd0);
        check({tag, " bclk"},  32'(dac_bclk),          32'd0);
        check({tag, " lrck"},  32'(dac_lrck),          32'd0);
        check({tag, " data"},  32'(dac_data),          32'd0);
        check({tag, " level"}, 32'(fifo_level),        32'd0);
        check({tag, " under"}, 32'(underrun_count),    32'd0);
    endtask

    // Second instance: requests permanently masked, so every frame underruns.
    int  t2 = 0;
    int  ones2 = 0;
    bit  done2 = 0;

    always @(posedge clk) begin
        if (rst2) t2 = 0;
        else      t2++;
    end

    always @(negedge clk) begin
        if (!rst2 && data2) ones2++;
    end

    initial begin
        int pts[5];
        int exp_u[5];
        pts   = '{3, 4, 4 + 128*253, 4 + 128*254, 4 + 128*258};
        exp_u = '{0, 1, 254, 255, 255};
        force dut2.w_req_ok = 1'b0;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            while (t2 < pts[i]) @(negedge clk);
            check("sat underrun", 32'(under2), 32'(exp_u[i]));
        end
        check("sat zero data", 32'(ones2),  32'd0);
        check("sat level",     32'(level2), 32'd0);
        check("sat no pulses", 32'(aoa2),   32'd0);
        done2 = 1;
    end

    typedef struct {
        int   cyc;
        logic aoa;
        int   lvl;
        logic bclk;
        logic data;
    } vec_t;

    initial begin
        vec_t        vecs[11];
        logic [31:0] w, lr;
        int          fs, g, u0;

        vecs[0]  = '{1,  1'b1, 0, 1'b0, 1'b0};
        vecs[1]  = '{2,  1'b0, 1, 1'b0, 1'b0};
        vecs[2]  = '{3,  1'b1, 1, 1'b0, 1'b0};
        vecs[3]  = '{4,  1'b0, 2, 1'b1, 1'b0};
        vecs[4]  = '{5,  1'b1, 2, 1'b1, 1'b0};
        vecs[5]  = '{6,  1'b0, 3, 1'b1, 1'b0};
        vecs[6]  = '{7,  1'b1, 3, 1'b1, 1'b0};
        vecs[7]  = '{8,  1'b0, 3, 1'b0, 1'b1};
        vecs[8]  = '{9,  1'b1, 3, 1'b0, 1'b1};
        vecs[9]  = '{10, 1'b0, 4, 1'b0, 1'b1};
        vecs[10] = '{11, 1'b0, 4, 1'b0, 1'b1};

        sample_l = 16'hA5C3;
        sample_r = 16'h0F0F;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst    = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 11; i++) begin
            wait_until(vecs[i].cyc);
            check("vec aoa",   32'(audio_out_allowed), 32'(vecs[i].aoa));
            check("vec level", 32'(fifo_level),        32'(vecs[i].lvl));
            check("vec bclk",  32'(dac_bclk),          32'(vecs[i].bclk));
            check("vec data",  32'(dac_data),          32'(vecs[i].data));
        end

        collect(2*C, w, lr);
        check("first frame bits", w,  32'hA5C30F0F);
        check("first frame lrck", lr, 32'h0000FFFF);
        check("first frame under", 32'(underrun_count), 32'd0);

        rand_voice = 1;
        rand_mask  = 1;
        repeat (6000) @(negedge clk);
        rand_mask  = 0;
        rand_voice = 0;

        // A write landing in an empty-FIFO pop cycle must wait for the next frame.
        set_mask(1'b1);
        g = 0;
        while (fifo_level != 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("drain empty", 32'(fifo_level), 32'd0);
        sample_l = 16'h8001;
        sample_r = 16'h7FFE;
        fs = next_frame(mt + 3);
        wait_until(fs - 2);
        set_mask(1'b0);
        wait_until(fs - 1);
        check("late pulse aoa",   32'(audio_out_allowed), 32'd1);
        check("late pulse level", 32'(fifo_level),        32'd0);
        set_mask(1'b1);
        u0 = m_under;
        wait_until(fs);
        check("pop-cycle level", 32'(fifo_level),     32'd1);
        check("pop-cycle under", 32'(underrun_count), 32'((u0 < 255) ? u0 + 1 : 255));
        collect(fs, w, lr);
        check("underrun frame bits", w,  32'h0);
        check("underrun frame lrck", lr, 32'h0000FFFF);
        wait_until(fs + FR - 1);
        check("held entry level", 32'(fifo_level), 32'd1);
        wait_until(fs + FR);
        check("next pop level", 32'(fifo_level), 32'd0);
        collect(fs + FR, w, lr);
        check("held entry bits", w, 32'h80017FFE);

        // Asynchronous reset mid-frame with a full FIFO.
        set_mask(1'b0);
        sample_l = 16'h5A5A;
        sample_r = 16'h3C3C;
        g = 0;
        while (fifo_level != 3'(D) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        fs = next_frame(mt + 3);
        wait_until(fs + 2*C*10 + 1);
        check("full before reset", 32'(fifo_level), 32'(D));
        @(posedge clk);
        #2;
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        check_reset_outputs("async reset");
        repeat (3) @(negedge clk);
        sample_l = 16'h1234;
        sample_r = 16'hFEDC;
        rst    = 1'b0;
        chk_en = 1'b1;
        collect(2*C, w, lr);
        check("post-reset frame bits", w,  32'h1234FEDC);
        check("post-reset frame lrck", lr, 32'h0000FFFF);

        g = 0;
        while (!done2 && g < 40000) begin
            @(negedge clk);
            g++;
        end
        check("saturation run finished", 32'(done2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
